pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Parametrised pipeline stall/flush controller for the 023-series soft core, replacing the fixed three-stage combinational sequencer. Generalises to STAGES pipeline stages with per-stage stall requests and two freeze modes (global freeze, or partial freeze with bubble insertion). Adds sequential behaviour: a multi-cycle soft-reset hold, an interrupt flush that is latched while the pipe is stalled, and an optional stall watchdog. Sits between the pipeline stage modules, the interrupt unit and the register group.

Parameters:
STAGES, 4, number of pipeline stages; index 0 = fetch, STAGES-1 = last stage before register-group writeback; minimum 2.
RST_HOLD, 4, cycles that all reset outputs stay asserted after reset or rst_ask; minimum 1.
FREEZE_ALL, 1, 1 = any stall freezes every stage and the register group; 0 = partial freeze with bubble insertion.
STALL_TIMEOUT, 1024, consecutive stall cycles before the watchdog flags; used only with PIPE_WDOG_EN.

Ports:
clk  in  1  core clock.
rst  in  1  reset, asynchronous, active-high.
stall_req  in  STAGES  stage i requests a stall; bit i from stage i.
int_ask  in  1  interrupt unit requests a pipeline flush.
rst_ask  in  1  soft CPU restart request.
stage_rst  out  STAGES  per-stage flush/clear.
stage_stop  out  STAGES  per-stage freeze.
grp_rst  out  1  register-group clear.
grp_stop  out  1  register-group write freeze.
int_ack  out  1  one-cycle pulse: flush for the interrupt issued this cycle.
hold_busy  out  1  reset hold in progress.
stall_timeout  out  1  sticky watchdog flag; 0 when PIPE_WDOG_EN is undefined.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- State: hold_cnt (width $clog2(RST_HOLD+1)), int_pend (1 bit), and, when the watchdog is compiled in, stall_cnt and the stall_timeout flag.
- rst asserted: hold_cnt <= RST_HOLD, int_pend <= 0, stall_cnt <= 0, stall_timeout <= 0.
- rst_ask sampled high at a clk edge:
  - same actions as rst, synchronously.
  - rst_ask held high keeps reloading hold_cnt.
- hold_cnt decrements each edge while nonzero and rst_ask is low.
- Outputs are combinational from state and inputs. Per-cycle priority is below.
  1. HOLD (hold_cnt != 0):
     - stage_rst all 1, grp_rst 1, hold_busy 1.
     - all stops 0, int_ack 0.
     - This is also every output's value during and immediately after reset.
     - int_ask seen in HOLD is discarded, not latched.
  2. STALL (any stall_req bit set, not HOLD). K = highest set bit index.
     - FREEZE_ALL=1: stage_stop all 1, grp_stop 1, stage_rst all 0.
     - FREEZE_ALL=0:
       - stage_stop[j]=1 for j<=K, 0 otherwise.
       - stage_rst[K+1]=1 (bubble) if K<STAGES-1; other stage_rst bits 0.
       - grp_stop = 1 only when K==STAGES-1.
     - grp_rst 0.
     - int_ask high in STALL sets int_pend at the edge; no flush is issued.
  3. FLUSH (no HOLD, no stall, and int_ask or int_pend):
     - stage_rst all 1, grp_rst 0, all stops 0, int_ack 1.
     - int_pend <= 0 at the edge.
     - One flush per request. The requester drops int_ask on int_ack; if int_ask is still high on the next cycle, that is a new request.
  4. IDLE: all outputs 0.
- Simultaneous events:
  - rst_ask with stall or int: rst_ask wins, and int_pend is cleared.
  - A stall_req arriving in the same cycle as a pending flush defers the flush; int_pend is kept.
- hold_busy = (hold_cnt != 0).

Optional Feature:
PIPE_WDOG_EN:
- Defined:
  - stall_cnt counts consecutive cycles in STALL and saturates at STALL_TIMEOUT.
  - It clears on any non-STALL cycle, rst or rst_ask.
  - When stall_cnt reaches STALL_TIMEOUT, stall_timeout is set. It stays set until rst or rst_ask.
  - The watchdog has no effect on the stall/flush outputs.
- Undefined: no stall_cnt register, stall_timeout tied 0.

Test Plan:
- Reset: assert rst 3 cycles, release -> stage_rst=4'b1111, grp_rst=1, hold_busy=1 for exactly 4 edges after release, then all outputs 0.
- Partial freeze, FREEZE_ALL=0: stall_req=4'b0010 -> stage_stop=4'b0011, stage_rst=4'b0100, grp_stop=0. stall_req=4'b1000 -> stage_stop=4'b1111, grp_stop=1, stage_rst=0.
- Deferred interrupt: stall_req[1]=1 for 5 cycles, int_ask pulse in cycle 2 -> no flush while stalled; first cycle after the stall: stage_rst=4'b1111, int_ack=1 for 1 cycle, grp_rst=0.
- Priority: rst_ask, int_ask and stall_req=4'b0001 in the same cycle -> HOLD for 4 cycles, int_pend cleared, no int_ack afterwards.
- Global mode, FREEZE_ALL=1: stall_req=4'b0001 -> stage_stop=4'b1111, grp_stop=1. int_ask in the same cycle -> flush on the first unstalled cycle.
- Watchdog, PIPE_WDOG_EN defined, STALL_TIMEOUT=8: 8 consecutive stall cycles -> stall_timeout=1 and it stays high after the stall ends; rst_ask -> 0. 7 stall cycles, then 1 idle, then 7 more -> stays 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: reset hold, per-stage stall with global or
// partial freeze, latched interrupt flush. Optional watchdog via PIPE_WDOG_EN.
module pipe_ctrl #(
  parameter int STAGES        = 4,
  parameter int RST_HOLD      = 4,
  parameter int FREEZE_ALL    = 1,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stall_req,
  input  logic              int_ask,
  input  logic              rst_ask,
  output logic [STAGES-1:0] stage_rst,
  output logic [STAGES-1:0] stage_stop,
  output logic              grp_rst,
  output logic              grp_stop,
  output logic              int_ack,
  output logic              hold_busy,
  output logic              stall_timeout
);

  localparam int          HW   = $clog2(RST_HOLD + 1);
  localparam int unsigned LAST = STAGES - 1;

  typedef enum logic [1:0] {
    MODE_IDLE,
    MODE_HOLD,
    MODE_STALL,
    MODE_FLUSH
  } mode_t;

  logic [HW-1:0] hold_cnt;
  logic          int_pend;
  logic          pend_next;
  mode_t         mode;
  int unsigned   k_hi;

  always_comb begin
    k_hi = 0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (stall_req[i]) k_hi = i;
    end

    mode = MODE_IDLE;
    if (hold_cnt != '0)             mode = MODE_HOLD;
    else if (|stall_req)            mode = MODE_STALL;
    else if (int_ask || int_pend)   mode = MODE_FLUSH;

    stage_rst  = '0;
    stage_stop = '0;
    grp_rst    = 1'b0;
    grp_stop   = 1'b0;
    int_ack    = 1'b0;
    pend_next  = 1'b0;

    case (mode)
      MODE_HOLD: begin
        stage_rst = '1;
        grp_rst   = 1'b1;
        pend_next = int_pend;
      end
      MODE_STALL: begin
        // Interrupt seen while stalled is remembered and flushed once the pipe moves.
        pend_next = int_pend | int_ask;
        if (FREEZE_ALL != 0) begin
          stage_stop = '1;
          grp_stop   = 1'b1;
        end else begin
          // Freeze everything up to the stalling stage and bubble the one after it.
          for (int unsigned j = 0; j < STAGES; j++) begin
            stage_stop[j] = (j <= k_hi);
            stage_rst[j]  = (j == k_hi + 1);
          end
          grp_stop = (k_hi == LAST);
        end
      end
      MODE_FLUSH: begin
        stage_rst = '1;
        int_ack   = 1'b1;
      end
      default: ;
    endcase
  end

  assign hold_busy = (hold_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= HW'(RST_HOLD);
      int_pend <= 1'b0;
    end else if (rst_ask) begin
      hold_cnt <= HW'(RST_HOLD);
      int_pend <= 1'b0;
    end else begin
      if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
      int_pend <= pend_next;
    end
  end

`ifdef PIPE_WDOG_EN
  localparam int CW = $clog2(STALL_TIMEOUT + 1);

  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] stall_cnt_nxt;
  logic          wdog_flag;

  always_comb begin
    stall_cnt_nxt = '0;
    if (mode == MODE_STALL) begin
      stall_cnt_nxt = (stall_cnt == CW'(STALL_TIMEOUT)) ? stall_cnt : stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      wdog_flag <= 1'b0;
    end else if (rst_ask) begin
      stall_cnt <= '0;
      wdog_flag <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt_nxt;
      if (stall_cnt_nxt == CW'(STALL_TIMEOUT)) wdog_flag <= 1'b1;
    end
  end

  assign stall_timeout = wdog_flag;
`else
  assign stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: one partial-freeze and one global-freeze
// instance share stimulus; expectations go through a scoreboard queue.
module tb_pipe_ctrl;

`ifdef PIPE_WDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] stall_req = '0;
  logic       int_ask = 1'b0;
  logic       rst_ask = 1'b0;

  logic [3:0] stage_rst0, stage_stop0, stage_rst1, stage_stop1;
  logic       grp_rst0, grp_stop0, int_ack0, hold_busy0, stall_timeout0;
  logic       grp_rst1, grp_stop1, int_ack1, hold_busy1, stall_timeout1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string      tag;
    logic [3:0] rst0, stop0, rst1, stop1;
    logic       gstop0, gstop1, grst, ack, busy, to;
  } exp_t;

  exp_t sb[$];

  pipe_ctrl #(.STAGES(4), .RST_HOLD(4), .FREEZE_ALL(0), .STALL_TIMEOUT(8)) u0 (
    .clk(clk), .rst(rst), .stall_req(stall_req), .int_ask(int_ask), .rst_ask(rst_ask),
    .stage_rst(stage_rst0), .stage_stop(stage_stop0), .grp_rst(grp_rst0),
    .grp_stop(grp_stop0), .int_ack(int_ack0), .hold_busy(hold_busy0),
    .stall_timeout(stall_timeout0)
  );

  pipe_ctrl #(.STAGES(4), .RST_HOLD(4), .FREEZE_ALL(1), .STALL_TIMEOUT(8)) u1 (
    .clk(clk), .rst(rst), .stall_req(stall_req), .int_ask(int_ask), .rst_ask(rst_ask),
    .stage_rst(stage_rst1), .stage_stop(stage_stop1), .grp_rst(grp_rst1),
    .grp_stop(grp_stop1), .int_ack(int_ack1), .hold_busy(hold_busy1),
    .stall_timeout(stall_timeout1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic compare();
    exp_t e;
    e = sb.pop_front();
    chk({e.tag, ".stage_rst0"},  stage_rst0,  e.rst0);
    chk({e.tag, ".stage_stop0"}, stage_stop0, e.stop0);
    chk({e.tag, ".grp_stop0"},   {3'b0, grp_stop0}, {3'b0, e.gstop0});
    chk({e.tag, ".stage_rst1"},  stage_rst1,  e.rst1);
    chk({e.tag, ".stage_stop1"}, stage_stop1, e.stop1);
    chk({e.tag, ".grp_stop1"},   {3'b0, grp_stop1}, {3'b0, e.gstop1});
    chk({e.tag, ".grp_rst"},     {2'b0, grp_rst1, grp_rst0},     {2'b0, e.grst, e.grst});
    chk({e.tag, ".int_ack"},     {2'b0, int_ack1, int_ack0},     {2'b0, e.ack, e.ack});
    chk({e.tag, ".hold_busy"},   {2'b0, hold_busy1, hold_busy0}, {2'b0, e.busy, e.busy});
    chk({e.tag, ".stall_timeout"}, {2'b0, stall_timeout1, stall_timeout0},
        {2'b0, e.to & WD, e.to & WD});
  endtask

  // Drive one cycle of inputs, queue its expectation, check mid-cycle.
  task automatic step(input string tag, input logic [3:0] sr, input logic ia, input logic ra,
                      input logic [3:0] er0, input logic [3:0] es0, input logic eg0,
                      input logic [3:0] er1, input logic [3:0] es1, input logic eg1,
                      input logic egr, input logic eack, input logic ebusy, input logic eto);
    exp_t e;
    stall_req = sr;
    int_ask   = ia;
    rst_ask   = ra;
    e.tag = tag;
    e.rst0 = er0; e.stop0 = es0; e.gstop0 = eg0;
    e.rst1 = er1; e.stop1 = es1; e.gstop1 = eg1;
    e.grst = egr; e.ack = eack; e.busy = ebusy; e.to = eto;
    sb.push_back(e);
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input logic to);
    step(tag, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0,
         1'b0, 1'b0, 1'b0, to);
  endtask

  task automatic hold(input string tag, input logic ia, input logic to);
    step(tag, 4'b0000, ia, 1'b0, 4'b1111, 4'b0000, 1'b0, 4'b1111, 4'b0000, 1'b0,
         1'b1, 1'b0, 1'b1, to);
  endtask

  task automatic flush(input string tag, input logic ia);
    step(tag, 4'b0000, ia, 1'b0, 4'b1111, 4'b0000, 1'b0, 4'b1111, 4'b0000, 1'b0,
         1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic stall1(input string tag, input logic ia, input logic to);
    step(tag, 4'b0010, ia, 1'b0, 4'b0100, 4'b0011, 1'b0, 4'b0000, 4'b1111, 1'b1,
         1'b0, 1'b0, 1'b0, to);
  endtask

  initial begin
    #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) hold("in_reset", 1'b0, 1'b0);
    rst = 1'b0;
    hold("hold1", 1'b0, 1'b0);
    hold("hold2", 1'b1, 1'b0);
    hold("hold3", 1'b0, 1'b0);
    hold("hold4", 1'b0, 1'b0);
    idle("after_hold", 1'b0);
    idle("int_in_hold_dropped", 1'b0);

    step("stall_b1", 4'b0010, 1'b0, 1'b0, 4'b0100, 4'b0011, 1'b0, 4'b0000, 4'b1111, 1'b1,
         1'b0, 1'b0, 1'b0, 1'b0);
    step("stall_b3", 4'b1000, 1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 4'b0000, 4'b1111, 1'b1,
         1'b0, 1'b0, 1'b0, 1'b0);
    step("stall_b2", 4'b0100, 1'b0, 1'b0, 4'b1000, 4'b0111, 1'b0, 4'b0000, 4'b1111, 1'b1,
         1'b0, 1'b0, 1'b0, 1'b0);
    step("stall_b0_b2", 4'b0101, 1'b0, 1'b0, 4'b1000, 4'b0111, 1'b0, 4'b0000, 4'b1111, 1'b1,
         1'b0, 1'b0, 1'b0, 1'b0);
    idle("idle_a", 1'b0);

    flush("direct_flush", 1'b1);
    flush("int_held_new_req", 1'b1);
    idle("idle_b", 1'b0);

    stall1("defer1", 1'b0, 1'b0);
    stall1("defer2_int", 1'b1, 1'b0);
    stall1("defer3", 1'b0, 1'b0);
    stall1("defer4", 1'b0, 1'b0);
    stall1("defer5", 1'b0, 1'b0);
    flush("deferred_flush", 1'b0);
    idle("after_deferred", 1'b0);

    step("prio_rst_ask", 4'b0001, 1'b1, 1'b1, 4'b0010, 4'b0001, 1'b0, 4'b0000, 4'b1111, 1'b1,
         1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) hold("prio_hold", 1'b0, 1'b0);
    idle("prio_no_ack", 1'b0);
    idle("prio_no_ack2", 1'b0);

    step("global_int", 4'b0001, 1'b1, 1'b0, 4'b0010, 4'b0001, 1'b0, 4'b0000, 4'b1111, 1'b1,
         1'b0, 1'b0, 1'b0, 1'b0);
    flush("global_flush", 1'b0);
    idle("idle_c", 1'b0);

    for (int i = 0; i < 7; i++) stall1("wd_run7a", 1'b0, 1'b0);
    idle("wd_gap", 1'b0);
    for (int i = 0; i < 7; i++) stall1("wd_run7b", 1'b0, 1'b0);
    idle("wd_gap2", 1'b0);
    for (int i = 0; i < 8; i++) stall1("wd_run8", 1'b0, 1'b0);
    idle("wd_flag", 1'b1);
    idle("wd_sticky", 1'b1);
    step("wd_rst_ask", 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0,
         1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) hold("wd_hold", 1'b0, 1'b0);
    idle("wd_cleared", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
